// File: rtl/pixel_write_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_write_fifo_pkg
//  Description : Shared definitions for the rasterizer write path. Holds the
//                default address and colour widths, the default FIFO depth,
//                the frame geometry constant shared with the line rasterizer,
//                and the packed {adr, color} FIFO entry type.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package pixel_write_fifo_pkg;

    // Default widths; they match the rasterizer's oAdr and colour register
    localparam int C_ADDR_W  = 16;
    localparam int C_COLOR_W = 8;
    localparam int C_DEPTH   = 16;

    // Frame is PIXELS_PER_LINE pixels wide; the rasterizer forms
    // adr = y * PIXELS_PER_LINE + x
    localparam int PIXELS_PER_LINE = 256;

    // One queued pixel write at the default widths
    typedef struct packed {
        logic [C_ADDR_W-1:0]  adr;
        logic [C_COLOR_W-1:0] color;
    } pixel_entry_t;

    // Pack an address/colour pair into a FIFO entry
    function automatic pixel_entry_t make_pixel(
        input logic [C_ADDR_W-1:0]  adr,
        input logic [C_COLOR_W-1:0] color
    );
        pixel_entry_t e;
        e.adr   = adr;
        e.color = color;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_fifo_ram
//  Description : DEPTH x WIDTH storage array for the pixel write FIFO.
//                Synchronous write port, asynchronous (combinational) read
//                port so the head entry is available in the same cycle it is
//                popped.
//  Ports       : clk        - clock, write on rising edge
//                i_wr_en    - write enable
//                i_wr_ptr   - write slot
//                i_wr_data  - entry to store
//                i_rd_ptr   - read slot
//                o_rd_data  - entry at i_rd_ptr (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_ptr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_ptr,
    output logic [WIDTH-1:0]         o_rd_data
);

    // Storage needs no reset: the control logic never reads a slot that
    // has not been written since the last reset.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/pixel_write_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_write_fifo
//  Description : Buffers the rasterizer's one-cycle pixel write strobes and
//                drains them into the single-port frame memory in cycles the
//                scan-out does not own it. The rasterizer cannot be stalled,
//                so a strobe arriving while full is dropped and flagged in a
//                sticky overflow bit.
//  Ports       : iClk, iRst_n       - clock, async active-low reset
//                iWrEn/iAdr/iColor  - pixel strobe from the rasterizer
//                iOvfClr            - clears oOverflow
//                iMemBusy           - scan-out owns frame memory this cycle
//                oMemAdr/oMemData/oMemWe - frame memory write port
//                oLevel/oFull       - occupancy status
//                oOverflow          - sticky dropped-pixel flag
//                oIdle              - nothing queued and no write in flight
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_write_fifo
    import pixel_write_fifo_pkg::*;
#(
    parameter int ADDR_W  = C_ADDR_W,
    parameter int COLOR_W = C_COLOR_W,
    parameter int DEPTH   = C_DEPTH
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic                     iWrEn,
    input  logic [ADDR_W-1:0]        iAdr,
    input  logic [COLOR_W-1:0]       iColor,
    input  logic                     iOvfClr,
    input  logic                     iMemBusy,
    output logic [ADDR_W-1:0]        oMemAdr,
    output logic [COLOR_W-1:0]       oMemData,
    output logic                     oMemWe,
    output logic [$clog2(DEPTH):0]   oLevel,
    output logic                     oFull,
    output logic                     oOverflow,
    output logic                     oIdle
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + COLOR_W;

    localparam logic [LVL_W-1:0] C_LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] C_LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               r_overflow;
    logic [ADDR_W-1:0]  r_mem_adr;
    logic [COLOR_W-1:0] r_mem_data;
    logic               r_mem_we;

    // ------------------------------------------------------------------
    // Handshake decisions, all based on the pre-edge level
    // ------------------------------------------------------------------
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_ovf_set;
    logic [LVL_W-1:0]   w_level_nxt;
    logic [ENTRY_W-1:0] w_wr_entry;
    logic [ENTRY_W-1:0] w_head_entry;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == C_LVL_FULL);

    // Drain whenever something is queued and scan-out leaves memory free
    assign w_pop   = !w_empty && !iMemBusy;

    // A pop at the same edge frees the slot, so a full FIFO still accepts
    // the strobe; the write lands in the slot the head is leaving, which is
    // safe because the head is read combinationally before the edge.
    assign w_push    = iWrEn && (!w_full || w_pop);
    assign w_ovf_set = iWrEn && w_full && !w_pop;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + C_LVL_ONE;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - C_LVL_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    assign w_wr_entry = {iAdr, iColor};

    pixel_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk       (iClk),
        .i_wr_en   (w_push),
        .i_wr_ptr  (r_wr_ptr),
        .i_wr_data (w_wr_entry),
        .i_rd_ptr  (r_rd_ptr),
        .o_rd_data (w_head_entry)
    );

    // ------------------------------------------------------------------
    // Pointers and level. Pointers are PTR_W bits wide and DEPTH is a
    // power of two, so they wrap modulo DEPTH on their own.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            r_level <= w_level_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sticky overflow; a new drop in the same cycle as a clear wins
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (iOvfClr) begin
            r_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Frame memory write port. Address/data hold their last value when no
    // write issues; only the enable is pulsed.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_mem_adr  <= '0;
            r_mem_data <= '0;
            r_mem_we   <= 1'b0;
        end else begin
            r_mem_we <= w_pop;
            if (w_pop) begin
                r_mem_adr  <= w_head_entry[ENTRY_W-1:COLOR_W];
                r_mem_data <= w_head_entry[COLOR_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign oMemAdr   = r_mem_adr;
    assign oMemData  = r_mem_data;
    assign oMemWe    = r_mem_we;
    assign oLevel    = r_level;
    assign oFull     = w_full;
    assign oOverflow = r_overflow;

    // A pixel still sitting on the write port has not landed yet
    assign oIdle     = w_empty && !r_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_pixel_write_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_write_fifo
//  Description : Scoreboard bench for pixel_write_fifo. Stimulus pushes the
//                expected frame-memory writes into a queue; a monitor pops
//                and compares on every cycle with oMemWe high.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pixel_write_fifo;
    import pixel_write_fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] adr;
    logic [7:0]  color;
    logic        ovf_clr;
    logic        mem_busy;
    logic [15:0] mem_adr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic [4:0]  level;
    logic        full;
    logic        overflow;
    logic        idle;

    int checks       = 0;
    int failures     = 0;
    int n_writes     = 0;
    int n_exp_writes = 0;

    pixel_entry_t sb[$];

    always #5 clk = ~clk;

    pixel_write_fifo #(
        .ADDR_W  (16),
        .COLOR_W (8),
        .DEPTH   (16)
    ) dut (
        .iClk      (clk),
        .iRst_n    (rst_n),
        .iWrEn     (wr_en),
        .iAdr      (adr),
        .iColor    (color),
        .iOvfClr   (ovf_clr),
        .iMemBusy  (mem_busy),
        .oMemAdr   (mem_adr),
        .oMemData  (mem_data),
        .oMemWe    (mem_we),
        .oLevel    (level),
        .oFull     (full),
        .oOverflow (overflow),
        .oIdle     (idle)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One-cycle strobe; accept says whether the bench expects it to land
    task automatic strobe(input logic [15:0] a, input logic [7:0] c, input bit accept);
        wr_en = 1'b1;
        adr   = a;
        color = c;
        if (accept) begin
            sb.push_back(make_pixel(a, c));
            n_exp_writes++;
        end
        next_cycle();
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            done = (idle === 1'b1) && (sb.size() == 0);
        end
        chk(name, {31'd0, done}, 32'd1);
        next_cycle();
    endtask

    // Monitor: every memory write must match the head of the scoreboard
    initial begin
        pixel_entry_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && mem_we === 1'b1) begin
                n_writes++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL mem_write unexpected adr=%h data=%h required=no write t=%0t",
                             mem_adr, mem_data, $time);
                end else begin
                    e = sb.pop_front();
                    if (mem_adr !== e.adr || mem_data !== e.color) begin
                        failures++;
                        $display("FAIL mem_write got adr=%h data=%h required adr=%h data=%h t=%0t",
                                 mem_adr, mem_data, e.adr, e.color, $time);
                    end
                end
            end
        end
    end

    initial begin
        int w0;
        int run;
        int sent;

        rst_n    = 1'b0;
        wr_en    = 1'b0;
        adr      = '0;
        color    = '0;
        ovf_clr  = 1'b0;
        mem_busy = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level",    {27'd0, level},    32'd0);
        chk("rst_we",       {31'd0, mem_we},   32'd0);
        chk("rst_idle",     {31'd0, idle},     32'd1);
        chk("rst_full",     {31'd0, full},     32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_mem_adr",  {16'd0, mem_adr},  32'd0);
        chk("rst_mem_data", {24'd0, mem_data}, 32'd0);
        rst_n = 1'b1;
        next_cycle();

        // ---------------- 1: async reset mid-stream ----------------
        mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) strobe(16'h0500 + 16'(i), 8'h11, 1'b1);
        chk("t1_level_before", {27'd0, level}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_async_level", {27'd0, level},  32'd0);
        chk("t1_async_we",    {31'd0, mem_we}, 32'd0);
        chk("t1_async_idle",  {31'd0, idle},   32'd1);
        sb.delete();
        n_exp_writes -= 5;
        w0 = n_writes;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        mem_busy = 1'b0;
        repeat (4) next_cycle();
        chk("t1_no_write_after", n_writes, w0);
        chk("t1_idle_after", {31'd0, idle}, 32'd1);

        // ---------------- 2: single pixel latency ----------------
        wr_en = 1'b1;
        adr   = 16'h1234;
        color = 8'hA5;
        sb.push_back(make_pixel(16'h1234, 8'hA5));
        n_exp_writes++;
        @(negedge clk);
        chk("t2_c0_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        wr_en = 1'b0;
        @(negedge clk);
        chk("t2_c1_we",    {31'd0, mem_we}, 32'd0);
        chk("t2_c1_level", {27'd0, level},  32'd1);
        @(negedge clk);
        chk("t2_c2_we",   {31'd0, mem_we},  32'd1);
        chk("t2_c2_adr",  {16'd0, mem_adr}, 32'h1234);
        chk("t2_c2_data", {24'd0, mem_data}, 32'hA5);
        @(negedge clk);
        chk("t2_c3_we",   {31'd0, mem_we}, 32'd0);
        chk("t2_c3_idle", {31'd0, idle},   32'd1);
        next_cycle();

        // ---------------- 3: fill while blocked, then drain ----------------
        mem_busy = 1'b1;
        w0 = n_writes;
        for (int i = 0; i < 16; i++) strobe(16'(i), 8'(i) ^ 8'h5A, 1'b1);
        chk("t3_full",      {31'd0, full},     32'd1);
        chk("t3_level",     {27'd0, level},    32'd16);
        chk("t3_no_write",  n_writes,          w0);
        chk("t3_overflow",  {31'd0, overflow}, 32'd0);
        chk("t3_idle_busy", {31'd0, idle},     32'd0);
        mem_busy = 1'b0;
        @(posedge clk);
        run = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (mem_we === 1'b1) run++;
        end
        chk("t3_consecutive_writes", run, 32'd16);
        wait_drain("t3_drain", 8);

        // ---------------- 4: overflow ----------------
        mem_busy = 1'b1;
        for (int i = 0; i < 16; i++) strobe(16'h0400 + 16'(i), 8'h40 + 8'(i), 1'b1);
        chk("t4_no_ovf_at_16", {31'd0, overflow}, 32'd0);
        strobe(16'h04FF, 8'hEE, 1'b0);
        chk("t4_ovf_at_17",   {31'd0, overflow}, 32'd1);
        chk("t4_level_at_17", {27'd0, level},    32'd16);
        mem_busy = 1'b0;
        wait_drain("t4_drain", 40);
        chk("t4_ovf_sticky", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        next_cycle();
        ovf_clr = 1'b0;
        chk("t4_ovf_cleared", {31'd0, overflow}, 32'd0);

        // ---------------- 5: push+pop while full ----------------
        mem_busy = 1'b1;
        for (int i = 0; i < 16; i++) strobe(16'h0200 + 16'(i), 8'h80 + 8'(i), 1'b1);
        chk("t5_level_full", {27'd0, level}, 32'd16);
        mem_busy = 1'b0;
        strobe(16'h0100, 8'hC3, 1'b1);
        chk("t5_level_kept", {27'd0, level},    32'd16);
        chk("t5_no_ovf",     {31'd0, overflow}, 32'd0);
        wait_drain("t5_drain", 40);

        // ---------------- 6: line with scan-out gaps ----------------
        sent = 0;
        for (int c = 0; sent < 240; c++) begin
            mem_busy = ((c % 4) == 3);
            if ((c % 4) != 0) begin
                wr_en = 1'b1;
                adr   = 16'(10 * PIXELS_PER_LINE + sent);
                color = 8'h3C;
                sb.push_back(make_pixel(adr, color));
                n_exp_writes++;
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            next_cycle();
        end
        wr_en    = 1'b0;
        mem_busy = 1'b0;
        wait_drain("t6_drain", 64);
        chk("t6_no_ovf", {31'd0, overflow}, 32'd0);

        // ---------------- totals ----------------
        chk("total_writes", n_writes, n_exp_writes);
        chk("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pixel_write_fifo.md
Name: pixel_write_fifo

Overview:
- Downstream stage of the line rasterizer. It consumes the rasterizer's one-cycle write strobes (frame address plus current colour) and buffers them in a small FIFO.
- It drains the FIFO into the single-port frame memory, but only in cycles the display scan-out does not own that memory.
- The rasterizer has no stall input, so overflow is detected, flagged sticky, and the pixel is dropped.
- oIdle lets the controller tell when a drawn primitive has fully landed in memory.

Parameters:
ADDR_W, 16, frame address width (matches rasterizer oAdr)
COLOR_W, 8, pixel colour width
DEPTH, 16, FIFO entries; power of two, >= 2

Ports:
iClk  in  1  clock, all logic on rising edge
iRst_n  in  1  reset, asynchronous, active-low
iWrEn  in  1  pixel write strobe from rasterizer (oWrEn)
iAdr  in  ADDR_W  pixel address from rasterizer (oAdr), valid when iWrEn
iColor  in  COLOR_W  drawing colour, sampled with iWrEn
iOvfClr  in  1  synchronous clear of oOverflow
iMemBusy  in  1  scan-out owns frame memory this cycle; no write may issue
oMemAdr  out  ADDR_W  frame memory address
oMemData  out  COLOR_W  frame memory write data
oMemWe  out  1  frame memory write enable, one cycle per pixel
oLevel  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
oFull  out  1  oLevel == DEPTH
oOverflow  out  1  sticky: a strobe arrived while the FIFO was full
oIdle  out  1  FIFO empty and oMemWe low

Behaviour:
- Reset (iRst_n low, asynchronous): pointers=0, oLevel=0, oMemWe=0, oMemAdr=0, oMemData=0, oOverflow=0. oIdle=1 and oFull=0 during and after reset. Reset mid-drain discards all queued pixels and any pending write.
- Pop: at each edge, pop if pre-edge oLevel>0 and iMemBusy=0.
  - On pop, the head {adr,color} is registered onto oMemAdr/oMemData and oMemWe=1 for the following cycle.
  - Otherwise oMemWe=0, and oMemAdr/oMemData hold their last value.
- Push: at each edge, push if iWrEn=1 and (pre-edge oLevel<DEPTH or a pop occurs at the same edge).
  - Simultaneous push+pop when full is accepted; the level is unchanged.
- Overflow: iWrEn=1 with oLevel==DEPTH and no pop at that edge drops the pixel and sets oOverflow.
  - oOverflow stays set until iOvfClr=1.
  - If iOvfClr and a new overflow coincide, the set wins.
- Level update: oLevel += push - pop, with no wrap. Pointers are ADDR-free log2(DEPTH)-bit counters that wrap modulo DEPTH.
- Latency: a strobe into an empty FIFO with iMemBusy=0 gives oMemWe=1 two cycles after the strobe cycle (push edge, then pop edge).
- Throughput: one pixel per cycle sustained while iMemBusy=0.
- Ordering: strict FIFO order. No coalescing of duplicate addresses.
- Back-to-back strobes with iMemBusy held high fill exactly DEPTH entries; strobe DEPTH+1 overflows.
- oIdle is combinational: (oLevel==0) && !oMemWe. The frame controller treats "rasterizer oDone && oIdle" as primitive complete.
- iAdr/iColor are don't-care when iWrEn=0. Nothing is captured.

Decomposition:
- Shared package: ADDR_W and COLOR_W defaults, the FIFO entry struct typedef {adr, color}, and the pixels-per-line constant shared with the rasterizer.
- One sub-module: pixel_fifo_ram, a DEPTH x (ADDR_W+COLOR_W) storage array with a synchronous write port and an asynchronous read port.
- Control logic (pointers, level, flags, memory output registers) lives in pixel_write_fifo.

Test Plan:
1. Reset: hold iRst_n=0 mid-stream with oLevel=5 -> oLevel=0, oMemWe=0, oIdle=1 immediately (async). No memory write after release.
2. Single pixel: iMemBusy=0, one strobe adr=0x1234 color=0xA5 in cycle 0 -> oMemWe=1, oMemAdr=0x1234, oMemData=0xA5 in cycle 2 only. oIdle=1 from cycle 3.
3. Fill and block: iMemBusy=1, DEPTH=16 strobes with adr 0..15 -> oFull=1, oLevel=16, no oMemWe. Drop iMemBusy -> 16 consecutive writes, adr 0..15 in order.
4. Overflow: iMemBusy=1, 17 strobes -> oOverflow=1 after strobe 17. Drain yields adr 0..15 only. Pulse iOvfClr -> oOverflow=0.
5. Full push+pop: level 16, iMemBusy=0, strobe adr=0x0100 -> no overflow, level stays 16. 0x0100 is written 16 pops later.
6. Busy gaps: drive 240 strobes like a Bresenham line (0..239 along one row) while iMemBusy toggles 1-of-4 cycles -> all 240 addresses written once, in order, with no overflow.
